// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Holds the FSM state encoding and bus widths.
package mem_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the responder.
// Master drives requests; slave answers.
interface mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_array.sv
// Single-port word storage with byte-masked write and registered read.
// Contents are intentionally not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [MASK_W-1:0] wmask_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < int'(MASK_W); b++) begin
                    if (wmask_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, waits LATENCY cycles,
// then presents a response until the initiator takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned       DEPTH_WORDS = 512,
    parameter int unsigned       LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned       IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH_WORDS) << 3;
    localparam logic [3:0]        LAT   = 4'(LATENCY);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic              accept;
    logic              access;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [MASK_W-1:0] a_wmask;
    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic [DATA_W-1:0] mem_rdata;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // Zero latency touches storage on the accept edge, so use live inputs.
    always_comb begin
        a_write = wr_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_wmask = wmask_q;
        if (state_q == ST_IDLE) begin
            a_write = bus.req_write;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_wmask = bus.req_wmask;
        end
    end

    assign off      = a_addr - BASE_ADDR;
    assign in_range = (a_addr >= BASE_ADDR) && (off < SPAN);

    // Storage is touched only on the edge entering RESP, never under reset.
    assign access = rst && ((accept && (LAT == 4'd0)) ||
                            ((state_q == ST_BUSY) && (cnt_q <= 4'd1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (LAT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = LAT;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) err_q <= !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wmask_q <= bus.req_wmask;
        end
    end

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (access),
        .we_i    (a_write && in_range),
        .idx_i   (off[IDX_W+2:3]),
        .wdata_i (a_wdata),
        .wmask_i (a_wmask),
        .rdata_o (mem_rdata)
    );

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata = ((state_q == ST_RESP) && !err_q && !wr_q)
                          ? mem_rdata : '0;

endmodule
